arith_divsi_guard: RTL and testbench
====================================

Name: arith_divsi_guard

Overview:
- Registered operand-guard stage directly upstream of the signed integer divider.
- Joins the dividend (a) and divisor (b) handshake streams and screens each pair for divide-by-zero and signed overflow (MIN / -1).
- Optionally substitutes safe operands, then buffers the pair in a 2-entry elastic FIFO so the divider sees only defined operand pairs.
- Keeps saturating fault counters for status readout.

Parameters:
- WIDTH, 32, operand width in bits (>= 2).
- CNT_WIDTH, 16, width of each fault counter.
- SANITIZE, 1: 1 = substitute safe operands on fault; 0 = pass operands unchanged and flag only.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  dividend valid.
- a_ready  output  1  dividend accepted.
- a_data  input  WIDTH  dividend, two's complement.
- b_valid  input  1  divisor valid.
- b_ready  output  1  divisor accepted.
- b_data  input  WIDTH  divisor, two's complement.
- out_valid  output  1  operand pair available.
- out_ready  input  1  downstream divider accepts the pair.
- out_a_data  output  WIDTH  guarded dividend.
- out_b_data  output  WIDTH  guarded divisor.
- out_fault  output  2  fault code of the head entry: 00 none, 01 div-by-zero, 10 overflow.
- cnt_clear  input  1  synchronous clear of both counters.
- zero_cnt  output  CNT_WIDTH  saturating count of div-by-zero pairs accepted.
- ovf_cnt  output  CNT_WIDTH  saturating count of overflow pairs accepted.

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low. While rst_n=0: FIFO empty, out_valid=0, out_a_data/out_b_data/out_fault=0, zero_cnt=ovf_cnt=0. Reset mid-operation discards buffered pairs immediately.
- Join: full = (count==2).
  - a_ready = b_valid & ~full; b_ready = a_valid & ~full.
  - push = a_valid & b_valid & ~full.
  - A lone valid never consumes its operand. Ready is never combinationally dependent on out_ready.
- Classification is evaluated on input data at push, with priority order:
  - b==0 -> fault 01.
  - Otherwise a==signed MIN (1 followed by WIDTH-1 zeros) and b==all-ones -> fault 10.
  - Otherwise fault 00.
- Substitution (SANITIZE=1):
  - Fault 01 stores a=0, b=1, giving quotient 0.
  - Fault 10 stores a unchanged, b=1, giving quotient MIN (wrapped result).
- SANITIZE=0: raw operands are stored; out_fault still reports the fault.
- FIFO:
  - 2 entries, storage {a, b, fault}, with read/write pointers and a 2-bit count.
  - Head outputs are driven from registers. out_valid = (count!=0).
  - pop = out_valid & out_ready.
- Latency: a pair pushed at edge k is visible at out_* after edge k, with out_valid=1 in cycle k+1. There is no combinational input-to-output path.
- Simultaneous push and pop:
  - count 1: count stays 1, head advances to the new entry.
  - count 2: push is impossible because ready is low.
  - count 0: pop is impossible.
- Throughput: 1 pair per cycle when out_ready is held at 1.
- Head stability: while out_valid=1 and out_ready=0, out_* hold stable.
- Pointers wrap modulo 2. When empty, out_a_data/out_b_data/out_fault hold their last values (don't-care to consumers).
- Counters:
  - Increment on push with fault 01 (zero_cnt) or fault 10 (ovf_cnt).
  - Saturate at all-ones with no wrap.
  - cnt_clear forces 0 and wins over a same-cycle increment.

Test Plan:
- Normal pair: a=100, b=-7, both valid, out_ready=1 -> one cycle later out_valid=1, out_a_data=100, out_b_data=-7 (0xFFFFFFF9), out_fault=00; counters stay 0.
- Divide-by-zero: a=55, b=0, SANITIZE=1 -> out_a_data=0, out_b_data=1, out_fault=01, zero_cnt=1. Repeat with SANITIZE=0 -> out_a_data=55, out_b_data=0, out_fault=01.
- Overflow: a=0x80000000, b=0xFFFFFFFF -> out_b_data=1, out_a_data=0x80000000, out_fault=10, ovf_cnt=1. Also a=0, b=0 -> fault 01, not 10.
- Backpressure and full:
  - out_ready=0, push pairs P1, P2 -> a_ready=b_ready=0 after the second push; P3 is held; outputs stay at P1.
  - Raise out_ready -> order P1, P2, P3 with no loss or duplication.
  - Steady out_ready=1 streaming -> one pair per cycle.
- Join skew: a_valid=1 for 3 cycles before b_valid rises -> a_ready=0 throughout; a single pair is pushed the cycle b_valid rises.
- Counters and reset:
  - CNT_WIDTH=2 with 5 zero-divisor pairs -> zero_cnt saturates at 3.
  - cnt_clear in the same cycle as a faulty push -> count = 0.
  - Assert rst_n=0 asynchronously mid-stream with 2 entries buffered -> out_valid=0 immediately, buffer empty after release.

Source files
------------

// File: rtl/arith_divsi_guard.sv
// Operand guard in front of the signed divider: joins a/b, screens
// divide-by-zero and MIN/-1, optionally sanitizes, buffers in a 2-deep FIFO.
module arith_divsi_guard #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16,
    parameter bit SANITIZE  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [WIDTH-1:0]     a_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [WIDTH-1:0]     b_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_a_data,
    output logic [WIDTH-1:0]     out_b_data,
    output logic [1:0]           out_fault,
    input  logic                 cnt_clear,
    output logic [CNT_WIDTH-1:0] zero_cnt,
    output logic [CNT_WIDTH-1:0] ovf_cnt
);

    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CMAX = {CNT_WIDTH{1'b1}};

    localparam logic [1:0] F_NONE = 2'b00;
    localparam logic [1:0] F_ZERO = 2'b01;
    localparam logic [1:0] F_OVF  = 2'b10;

    logic [1:0]       count;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [WIDTH-1:0] mem_a [2];
    logic [WIDTH-1:0] mem_b [2];
    logic [1:0]       mem_f [2];

    logic             full;
    logic             push;
    logic             pop;
    logic [1:0]       fault;
    logic [WIDTH-1:0] store_a;
    logic [WIDTH-1:0] store_b;

    assign full      = (count == 2'd2);
    assign a_ready   = b_valid & ~full;
    assign b_ready   = a_valid & ~full;
    assign push      = a_valid & b_valid & ~full;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & out_ready;

    assign out_a_data = mem_a[rd_ptr];
    assign out_b_data = mem_b[rd_ptr];
    assign out_fault  = mem_f[rd_ptr];

    // Classify the incoming pair (zero divisor outranks overflow) and pick stored operands.
    always_comb begin
        fault   = F_NONE;
        store_a = a_data;
        store_b = b_data;
        if (b_data == ZERO) begin
            fault = F_ZERO;
            if (SANITIZE) begin
                store_a = ZERO;
                store_b = ONE;
            end
        end else if (a_data == SMIN && b_data == ONES) begin
            fault = F_OVF;
            if (SANITIZE) begin
                store_b = ONE;
            end
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_a[i] <= ZERO;
                mem_b[i] <= ZERO;
                mem_f[i] <= F_NONE;
            end
        end else begin
            if (push) begin
                mem_a[wr_ptr] <= store_a;
                mem_b[wr_ptr] <= store_b;
                mem_f[wr_ptr] <= fault;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Saturating fault counters; clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_cnt <= '0;
            ovf_cnt  <= '0;
        end else if (cnt_clear) begin
            zero_cnt <= '0;
            ovf_cnt  <= '0;
        end else if (push) begin
            if (fault == F_ZERO && zero_cnt != CMAX) begin
                zero_cnt <= zero_cnt + 1'b1;
            end
            if (fault == F_OVF && ovf_cnt != CMAX) begin
                ovf_cnt <= ovf_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arith_divsi_guard.sv
// Directed bench for arith_divsi_guard: default, raw-operand and
// narrow-counter instances share one stimulus stream.
module tb_arith_divsi_guard;

    logic        clk;
    logic        rst_n;
    logic        a_valid, b_valid, out_ready, cnt_clear;
    logic [31:0] a_data, b_data;

    logic        m_ar, m_br, m_ov;
    logic [31:0] m_a, m_b;
    logic [1:0]  m_f;
    logic [15:0] m_zc, m_oc;

    logic        r_ar, r_br, r_ov;
    logic [31:0] r_a, r_b;
    logic [1:0]  r_f;
    logic [15:0] r_zc, r_oc;

    logic        n_ar, n_br, n_ov;
    logic [31:0] n_a, n_b;
    logic [1:0]  n_f;
    logic [1:0]  n_zc, n_oc;

    int compared = 0;
    int mismatched = 0;

    arith_divsi_guard #(.WIDTH(32), .CNT_WIDTH(16), .SANITIZE(1'b1)) u_main (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(m_ar), .a_data(a_data),
        .b_valid(b_valid), .b_ready(m_br), .b_data(b_data),
        .out_valid(m_ov), .out_ready(out_ready),
        .out_a_data(m_a), .out_b_data(m_b), .out_fault(m_f),
        .cnt_clear(cnt_clear), .zero_cnt(m_zc), .ovf_cnt(m_oc)
    );

    arith_divsi_guard #(.WIDTH(32), .CNT_WIDTH(16), .SANITIZE(1'b0)) u_raw (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(r_ar), .a_data(a_data),
        .b_valid(b_valid), .b_ready(r_br), .b_data(b_data),
        .out_valid(r_ov), .out_ready(out_ready),
        .out_a_data(r_a), .out_b_data(r_b), .out_fault(r_f),
        .cnt_clear(cnt_clear), .zero_cnt(r_zc), .ovf_cnt(r_oc)
    );

    arith_divsi_guard #(.WIDTH(32), .CNT_WIDTH(2), .SANITIZE(1'b1)) u_narrow (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(n_ar), .a_data(a_data),
        .b_valid(b_valid), .b_ready(n_br), .b_data(b_data),
        .out_valid(n_ov), .out_ready(out_ready),
        .out_a_data(n_a), .out_b_data(n_b), .out_fault(n_f),
        .cnt_clear(cnt_clear), .zero_cnt(n_zc), .ovf_cnt(n_oc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [1:0]  ef;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic bv, input logic [31:0] a, input logic [31:0] b);
        a_valid = av;
        b_valid = bv;
        a_data  = a;
        b_data  = b;
    endtask

    int exp_zero;
    int exp_ovf;

    initial begin
        vecs[0] = '{32'd100,      32'hFFFF_FFF9, 32'd100,      32'hFFFF_FFF9, 2'b00};
        vecs[1] = '{32'd55,       32'd0,         32'd0,        32'd1,         2'b01};
        vecs[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,       2'b10};
        vecs[3] = '{32'd0,        32'd0,         32'd0,        32'd1,         2'b01};
        vecs[4] = '{32'h8000_0000, 32'd0,        32'd0,        32'd1,         2'b01};
        vecs[5] = '{32'h8000_0000, 32'd1,        32'h8000_0000, 32'd1,        2'b00};
        vecs[6] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b00};
        vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00};
        vecs[8] = '{32'd123,      32'd0,         32'd0,        32'd1,         2'b01};
        vecs[9] = '{32'd5,        32'd0,         32'd0,        32'd1,         2'b01};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        out_ready = 1'b0;
        cnt_clear = 1'b0;
        #3;
        chk("rst_out_valid", {31'd0, m_ov}, 32'd0);
        chk("rst_out_a", m_a, 32'd0);
        chk("rst_out_b", m_b, 32'd0);
        chk("rst_out_fault", {30'd0, m_f}, 32'd0);
        chk("rst_zero_cnt", {16'd0, m_zc}, 32'd0);
        chk("rst_ovf_cnt", {16'd0, m_oc}, 32'd0);
        #9;
        rst_n = 1'b1;
        step();

        exp_zero = 0;
        exp_ovf  = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, vecs[i].a, vecs[i].b);
            step();
            if (vecs[i].ef == 2'b01) exp_zero++;
            if (vecs[i].ef == 2'b10) exp_ovf++;
            chk($sformatf("v%0d_valid", i), {31'd0, m_ov}, 32'd1);
            chk($sformatf("v%0d_a", i), m_a, vecs[i].ea);
            chk($sformatf("v%0d_b", i), m_b, vecs[i].eb);
            chk($sformatf("v%0d_fault", i), {30'd0, m_f}, {30'd0, vecs[i].ef});
            chk($sformatf("v%0d_raw_a", i), r_a, vecs[i].a);
            chk($sformatf("v%0d_raw_b", i), r_b, vecs[i].b);
            chk($sformatf("v%0d_raw_fault", i), {30'd0, r_f}, {30'd0, vecs[i].ef});
            chk($sformatf("v%0d_zero_cnt", i), {16'd0, m_zc}, exp_zero);
            chk($sformatf("v%0d_ovf_cnt", i), {16'd0, m_oc}, exp_ovf);
            chk($sformatf("v%0d_narrow_zero", i), {30'd0, n_zc},
                (exp_zero > 3) ? 32'd3 : exp_zero);
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        step();
        chk("drain_valid", {31'd0, m_ov}, 32'd0);
        chk("narrow_sat", {30'd0, n_zc}, 32'd3);
        chk("raw_zero_cnt", {16'd0, r_zc}, 32'd5);

        cnt_clear = 1'b1;
        drive(1'b1, 1'b1, 32'd9, 32'd0);
        step();
        cnt_clear = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        chk("clear_fault", {30'd0, m_f}, 32'd1);
        chk("clear_zero_cnt", {16'd0, m_zc}, 32'd0);
        chk("clear_ovf_cnt", {16'd0, m_oc}, 32'd0);
        chk("clear_narrow", {30'd0, n_zc}, 32'd0);
        step();

        out_ready = 1'b0;
        drive(1'b1, 1'b1, 32'd1, 32'd2);
        step();
        chk("bp_ready_after_p1", {31'd0, m_ar}, 32'd1);
        drive(1'b1, 1'b1, 32'd3, 32'd4);
        step();
        chk("bp_a_ready_full", {31'd0, m_ar}, 32'd0);
        chk("bp_b_ready_full", {31'd0, m_br}, 32'd0);
        chk("bp_head_p1", m_a, 32'd1);
        drive(1'b1, 1'b1, 32'd5, 32'd6);
        step();
        step();
        chk("bp_hold_a", m_a, 32'd1);
        chk("bp_hold_b", m_b, 32'd2);
        chk("bp_hold_valid", {31'd0, m_ov}, 32'd1);
        out_ready = 1'b1;
        step();
        chk("bp_order_p2", m_a, 32'd3);
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        chk("bp_order_p3", m_a, 32'd5);
        chk("bp_order_p3_b", m_b, 32'd6);
        chk("bp_p3_valid", {31'd0, m_ov}, 32'd1);
        step();
        chk("bp_empty", {31'd0, m_ov}, 32'd0);

        drive(1'b1, 1'b0, 32'd77, 32'd11);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("skew_a_ready%0d", k), {31'd0, m_ar}, 32'd0);
            step();
            chk($sformatf("skew_no_push%0d", k), {31'd0, m_ov}, 32'd0);
        end
        b_valid = 1'b1;
        #1;
        chk("skew_a_ready_rise", {31'd0, m_ar}, 32'd1);
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        chk("skew_pushed", {31'd0, m_ov}, 32'd1);
        chk("skew_data", m_a, 32'd77);
        step();
        chk("skew_single", {31'd0, m_ov}, 32'd0);

        out_ready = 1'b0;
        drive(1'b1, 1'b1, 32'd10, 32'd0);
        step();
        drive(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        chk("arst_full", {31'd0, m_ar | m_br}, 32'd0);
        chk("arst_pre_ovf", {16'd0, m_oc}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid_now", {31'd0, m_ov}, 32'd0);
        chk("arst_cnt_now", {16'd0, m_zc}, 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        chk("arst_empty_after", {31'd0, m_ov}, 32'd0);
        chk("arst_ovf_after", {16'd0, m_oc}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
